// File: rtl/output_wrapper_pkg.sv
// Shared types and constants for the result-side output wrapper.
// Imported by the interface, the control unit and the top.
package output_wrapper_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ow_state_e;

  localparam int DEF_RES_W = 32;
  localparam int DEF_BUS_W = 8;

  function automatic int nbytes(input int res_w, input int bus_w);
    return res_w / bus_w;
  endfunction

  // A single-beat result still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_wrapper_if.sv
// Core-result / byte-bus signal bundle of the output wrapper.
// The wrapper uses the master view; the core and receiver use the slave view.
interface output_wrapper_if
  import output_wrapper_pkg::*;
#(
  parameter int RES_W = DEF_RES_W,
  parameter int BUS_W = DEF_BUS_W
);
  logic             done;
  logic [RES_W-1:0] result;
  logic             out_accepted;
  logic [BUS_W-1:0] Bus_out;
  logic             out_ready;
  logic             empty_buffer;
  logic             busy;
  logic             overrun;

  modport master (
    input  done, result, out_accepted,
    output Bus_out, out_ready, empty_buffer, busy, overrun
  );

  modport slave (
    output done, result, out_accepted,
    input  Bus_out, out_ready, empty_buffer, busy, overrun
  );
endinterface

// File: rtl/output_wrapper_cu.sv
// Control unit of the output wrapper: transfer FSM, datapath strobes
// and the sticky overrun flag.
module output_wrapper_cu
  import output_wrapper_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic done,
  input  logic accepted,
  input  logic last,
  output logic load,
  output logic shift,
  output logic inc,
  output logic clr,
  output logic send_next,
  output logic out_ready,
  output logic overrun
);
  ow_state_e state_r;
  ow_state_e state_next_s;
  logic      overrun_r;
  logic      overrun_set_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a done on the final handshake keeps us in SEND
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (done) state_next_s = SEND;
        else      state_next_s = IDLE;
      end
      SEND: begin
        if (accepted && last && !done) state_next_s = IDLE;
        else                           state_next_s = SEND;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath strobes and overrun detection
  always_comb begin
    load          = 1'b0;
    shift         = 1'b0;
    inc           = 1'b0;
    clr           = 1'b0;
    overrun_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (done) begin
          load = 1'b1;
          clr  = 1'b1;
        end else begin
          load = 1'b0;
        end
      end
      SEND: begin
        if (accepted && last) begin
          load = done;
          clr  = done;
        end else if (accepted) begin
          shift         = 1'b1;
          inc           = 1'b1;
          overrun_set_s = done;
        end else begin
          overrun_set_s = done;
        end
      end
      default: begin
        load = 1'b0;
      end
    endcase
    send_next = (state_next_s == SEND);
    out_ready = (state_r == SEND);
    overrun   = overrun_r;
  end

  // Sticky overrun flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_r <= 1'b0;
    end else if (overrun_set_s) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

endmodule

// File: rtl/output_wrapper.sv
// Output wrapper top: captures the core result and serialises it LSB byte
// first over a valid/ready bus; holding register and counter live here.
module output_wrapper
  import output_wrapper_pkg::*;
#(
  parameter int RES_W = DEF_RES_W,
  parameter int BUS_W = DEF_BUS_W
) (
  input  logic             clk,
  input  logic             rst,
  output_wrapper_if.master bus
);
  localparam int              NBYTES   = nbytes(RES_W, BUS_W);
  localparam int              CNT_W    = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  logic [RES_W-1:0] hold_r;
  logic [RES_W-1:0] hold_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [BUS_W-1:0] bus_r;
  logic             load_s;
  logic             shift_s;
  logic             inc_s;
  logic             clr_s;
  logic             send_next_s;
  logic             out_ready_s;
  logic             overrun_s;
  logic             last_s;

  assign last_s = (cnt_r == LAST_CNT);

  output_wrapper_cu u_cu (
    .clk       (clk),
    .rst       (rst),
    .done      (bus.done),
    .accepted  (bus.out_accepted),
    .last      (last_s),
    .load      (load_s),
    .shift     (shift_s),
    .inc       (inc_s),
    .clr       (clr_s),
    .send_next (send_next_s),
    .out_ready (out_ready_s),
    .overrun   (overrun_s)
  );

  // Next holding-register value: load a fresh result or drop the sent byte
  always_comb begin
    hold_next_s = hold_r;
    if (load_s) begin
      hold_next_s = bus.result;
    end else if (shift_s) begin
      hold_next_s = hold_r >> BUS_W;
    end else begin
      hold_next_s = hold_r;
    end
  end

  // Holding register plus the byte that will be on the bus next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_r <= {RES_W{1'b0}};
      bus_r  <= {BUS_W{1'b0}};
    end else begin
      hold_r <= hold_next_s;
      bus_r  <= send_next_s ? hold_next_s[BUS_W-1:0] : {BUS_W{1'b0}};
    end
  end

  // Beat counter; never passes NBYTES-1 because the last beat clears or idles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.Bus_out      = bus_r;
  assign bus.out_ready    = out_ready_s;
  assign bus.empty_buffer = ~out_ready_s;
  assign bus.busy         = out_ready_s;
  assign bus.overrun      = overrun_s;

endmodule
